// File: rtl/bus_timer.sv
// bus_timer: memory-mapped timer/interrupt peripheral on bus slave1.
//
// Register map (byte address bits [3:2]):
//   0 CTRL    : bit0 EN, bit1 PERIODIC, bit2 IE, [15:8] PRESCALE
//   1 COUNT   : read/write counter
//   2 COMPARE : read/write match value
//   3 STATUS  : bit0 PENDING, write 1 to clear
//
// Optional feature macro: TIMER_PRESCALER_EN
//   Defined   : CTRL[15:8] PRESCALE is implemented; one tick every PRESCALE+1
//               cycles while EN=1.
//   Undefined : PRESCALE reads 0, writes are ignored; one tick per cycle
//               while EN=1.
//
// Read data and irq are combinational from the registers because the bus
// expects rdata in the same cycle as the access.

`default_nettype none

module bus_timer #(
    parameter int CNT_WIDTH      = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        slave_we,
    input  logic [31:0] slave_adr,
    input  logic [31:0] slave_wdata,
    output logic [31:0] slave_rdata,
    output logic        irq
);

    // Register selector values for slave_adr[3:2].
    localparam logic [1:0] SEL_CTRL    = 2'd0;
    localparam logic [1:0] SEL_COUNT   = 2'd1;
    localparam logic [1:0] SEL_COMPARE = 2'd2;
    localparam logic [1:0] SEL_STATUS  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ALLONES = {CNT_WIDTH{1'b1}};

    // Zero-extend a counter-width value onto the 32-bit read bus.
    function automatic logic [31:0] zext_cnt(input logic [CNT_WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[CNT_WIDTH-1:0] = v;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic                 en_r;
    logic                 periodic_r;
    logic                 ie_r;
    logic                 pending_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] compare_r;

`ifdef TIMER_PRESCALER_EN
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic [PRESCALE_WIDTH-1:0] pre_cnt_r;
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [1:0] sel_s;
    logic       wr_ctrl_s;
    logic       wr_count_s;
    logic       wr_compare_s;
    logic       wr_status_s;

    // Only bits [3:2] of the address select a register; the rest are
    // already resolved by the bus interconnect.
    assign sel_s = slave_adr[3:2];

    // Per-register write strobes.
    always_comb begin
        wr_ctrl_s    = 1'b0;
        wr_count_s   = 1'b0;
        wr_compare_s = 1'b0;
        wr_status_s  = 1'b0;
        if (slave_we) begin
            case (sel_s)
                SEL_CTRL:    wr_ctrl_s    = 1'b1;
                SEL_COUNT:   wr_count_s   = 1'b1;
                SEL_COMPARE: wr_compare_s = 1'b1;
                SEL_STATUS:  wr_status_s  = 1'b1;
                default: begin
                    wr_ctrl_s    = 1'b0;
                    wr_count_s   = 1'b0;
                    wr_compare_s = 1'b0;
                    wr_status_s  = 1'b0;
                end
            endcase
        end else begin
            wr_ctrl_s    = 1'b0;
            wr_count_s   = 1'b0;
            wr_compare_s = 1'b0;
            wr_status_s  = 1'b0;
        end
    end

    // Address bits outside [3:2] and data bits beyond the implemented
    // fields are intentionally ignored; fold them into one dead net.
    logic unused_bits_s;
    assign unused_bits_s = ^{slave_adr, slave_wdata};

    // ------------------------------------------------------------------
    // Tick and match generation
    // ------------------------------------------------------------------
    logic tick_s;
    logic match_s;
    logic clr_pend_s;

`ifdef TIMER_PRESCALER_EN
    // Tick once per PRESCALE+1 cycles while enabled.
    always_comb begin
        tick_s = 1'b0;
        if (en_r && (pre_cnt_r == prescale_r)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end
`else
    // Without a prescaler the timer ticks on every enabled cycle.
    always_comb begin
        tick_s = en_r;
    end
`endif

    // A match needs a tick: COUNT==COMPARE alone does nothing while stopped.
    always_comb begin
        match_s    = tick_s && (count_r == compare_r);
        clr_pend_s = wr_status_s && slave_wdata[0];
    end

`ifdef TIMER_PRESCALER_EN
    // PRESCALE field; a CTRL write replaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_r <= {PRESCALE_WIDTH{1'b0}};
        end else if (wr_ctrl_s) begin
            prescale_r <= slave_wdata[8 +: PRESCALE_WIDTH];
        end else begin
            prescale_r <= prescale_r;
        end
    end

    // Prescale counter 0..PRESCALE; restarts whenever the timer is
    // stopped or CTRL is rewritten so a new setting starts a full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r <= {PRESCALE_WIDTH{1'b0}};
        end else if (!en_r || wr_ctrl_s) begin
            pre_cnt_r <= {PRESCALE_WIDTH{1'b0}};
        end else if (pre_cnt_r == prescale_r) begin
            pre_cnt_r <= {PRESCALE_WIDTH{1'b0}};
        end else begin
            pre_cnt_r <= pre_cnt_r + PRESCALE_WIDTH'(1'b1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Register updates
    // ------------------------------------------------------------------

    // CTRL flags; a software write wins over the one-shot auto-stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_r       <= 1'b0;
            periodic_r <= 1'b0;
            ie_r       <= 1'b0;
        end else if (wr_ctrl_s) begin
            en_r       <= slave_wdata[0];
            periodic_r <= slave_wdata[1];
            ie_r       <= slave_wdata[2];
        end else if (match_s && !periodic_r) begin
            en_r       <= 1'b0;
            periodic_r <= periodic_r;
            ie_r       <= ie_r;
        end else begin
            en_r       <= en_r;
            periodic_r <= periodic_r;
            ie_r       <= ie_r;
        end
    end

    // COUNT: software write wins over increment/clear from the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else if (wr_count_s) begin
            count_r <= slave_wdata[CNT_WIDTH-1:0];
        end else if (match_s) begin
            count_r <= CNT_ZERO;
        end else if (tick_s) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // COMPARE: plain read/write register, all ones out of reset so an
    // enabled-but-unprogrammed timer takes a full wrap before matching.
    always_ff @(posedge clk) begin
        if (rst) begin
            compare_r <= CNT_ALLONES;
        end else if (wr_compare_s) begin
            compare_r <= slave_wdata[CNT_WIDTH-1:0];
        end else begin
            compare_r <= compare_r;
        end
    end

    // PENDING: a hardware set beats a simultaneous W1C so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 1'b0;
        end else if (match_s) begin
            pending_r <= 1'b1;
        end else if (clr_pend_s) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Level interrupt; IE masks it without touching PENDING.
    always_comb begin
        irq = pending_r & ie_r;
    end

    // Read mux; reads have no side effects.
    always_comb begin
        slave_rdata = 32'd0;
        case (sel_s)
            SEL_CTRL: begin
                slave_rdata[0] = en_r;
                slave_rdata[1] = periodic_r;
                slave_rdata[2] = ie_r;
`ifdef TIMER_PRESCALER_EN
                slave_rdata[8 +: PRESCALE_WIDTH] = prescale_r;
`endif
            end
            SEL_COUNT:   slave_rdata = zext_cnt(count_r);
            SEL_COMPARE: slave_rdata = zext_cnt(compare_r);
            SEL_STATUS:  slave_rdata[0] = pending_r;
            default:     slave_rdata = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer (default 32-bit counter).
// Inputs change on the falling edge; outputs are checked 1ns or more after
// the rising edge, well before the next falling edge.

`timescale 1ns/1ps

module tb_bus_timer;

    logic        clk;
    logic        rst;
    logic        slave_we;
    logic [31:0] slave_adr;
    logic [31:0] slave_wdata;
    logic [31:0] slave_rdata;
    logic        irq;

    int checks;
    int errors;

    localparam logic [31:0] A_CTRL    = 32'h2000_0000;
    localparam logic [31:0] A_COUNT   = 32'h2000_0004;
    localparam logic [31:0] A_COMPARE = 32'h2000_0008;
    localparam logic [31:0] A_STATUS  = 32'h2000_000C;

    bus_timer dut (
        .clk         (clk),
        .rst         (rst),
        .slave_we    (slave_we),
        .slave_adr   (slave_adr),
        .slave_wdata (slave_wdata),
        .slave_rdata (slave_rdata),
        .irq         (irq)
    );

    // 20ns clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        slave_adr = adr;
        #1;
        chk(tag, slave_rdata, exp);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    // Write commits on the rising edge; returns 1ns after that edge.
    task automatic wr(input logic [31:0] adr, input logic [31:0] data);
        @(negedge clk);
        slave_we    = 1'b1;
        slave_adr   = adr;
        slave_wdata = data;
        @(posedge clk);
        #1;
        slave_we    = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        slave_we    = 1'b0;
        slave_adr   = 32'd0;
        slave_wdata = 32'd0;

        // 1. Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_irq(1'b0, "rst_irq");
        rd(A_CTRL,    32'h0000_0000, "rst_ctrl");
        rd(A_COUNT,   32'h0000_0000, "rst_count");
        rd(A_COMPARE, 32'hFFFF_FFFF, "rst_compare");
        rd(A_STATUS,  32'h0000_0000, "rst_status");

        // 2. One-shot: COMPARE=5, match 6 edges after the CTRL write
        wr(A_COMPARE, 32'd5);
        wr(A_COUNT,   32'd0);
        wr(A_CTRL,    32'h0000_0005);
        step(5);
        rd(A_COUNT,  32'd5, "os_count_t5");
        chk_irq(1'b0, "os_irq_t5");
        rd(A_STATUS, 32'd0, "os_status_t5");
        step(1);
        chk_irq(1'b1, "os_irq_t6");
        rd(A_STATUS, 32'd1, "os_status_t6");
        rd(A_CTRL,   32'h0000_0004, "os_ctrl_t6");
        rd(A_COUNT,  32'd0, "os_count_t6");
        step(2);
        rd(A_COUNT,  32'd0, "os_count_hold");

        // 3. Periodic with W1C clear
        wr(A_STATUS,  32'd1);
        rd(A_STATUS,  32'd0, "per_w1c_idle");
        wr(A_COMPARE, 32'd3);
        wr(A_COUNT,   32'd0);
        wr(A_CTRL,    32'h0000_0007);
        step(3);
        chk_irq(1'b0, "per_irq_t3");
        rd(A_COUNT, 32'd3, "per_count_t3");
        step(1);
        chk_irq(1'b1, "per_irq_t4");
        rd(A_COUNT, 32'd0, "per_count_t4");
        wr(A_STATUS, 32'd1);
        chk_irq(1'b0, "per_irq_cleared");
        step(2);
        chk_irq(1'b0, "per_irq_t7");
        step(1);
        chk_irq(1'b1, "per_irq_t8");
        step(3);
        wr(A_STATUS, 32'd1);
        chk_irq(1'b1, "per_w1c_vs_match_irq");
        rd(A_STATUS, 32'd1, "per_w1c_vs_match_status");
        wr(A_CTRL,   32'h0000_0000);
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, 32'd0, "per_stop_status");

        // 4. Masked interrupt and wrap
        wr(A_COUNT,   32'hFFFF_FFFE);
        wr(A_COMPARE, 32'd1);
        wr(A_CTRL,    32'h0000_0003);
        step(1);
        rd(A_COUNT, 32'hFFFF_FFFF, "wrap_count_1");
        step(1);
        rd(A_COUNT, 32'h0000_0000, "wrap_count_2");
        step(1);
        rd(A_COUNT,  32'd1, "wrap_count_3");
        rd(A_STATUS, 32'd0, "wrap_status_3");
        step(1);
        rd(A_COUNT,  32'd0, "wrap_count_4");
        rd(A_STATUS, 32'd1, "wrap_status_4");
        chk_irq(1'b0, "wrap_irq_masked");
        wr(A_CTRL, 32'h0000_0007);
        chk_irq(1'b1, "wrap_irq_unmasked");
        rd(A_CTRL, 32'h0000_0007, "wrap_ctrl");

        // 5. COUNT write beats tick; reset beats simultaneous write
        wr(A_COUNT, 32'd100);
        rd(A_COUNT, 32'd100, "prio_count_write");
        step(1);
        rd(A_COUNT, 32'd101, "prio_count_next");
        @(negedge clk);
        rst         = 1'b1;
        slave_we    = 1'b1;
        slave_adr   = A_COMPARE;
        slave_wdata = 32'd7;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        slave_we = 1'b0;
        chk_irq(1'b0, "mid_rst_irq");
        rd(A_CTRL,    32'h0000_0000, "mid_rst_ctrl");
        rd(A_COUNT,   32'h0000_0000, "mid_rst_count");
        rd(A_COMPARE, 32'hFFFF_FFFF, "mid_rst_compare");
        rd(A_STATUS,  32'h0000_0000, "mid_rst_status");

        // 6. Prescaler (or its absence)
        wr(A_COMPARE, 32'd2);
        wr(A_COUNT,   32'd0);
        wr(A_CTRL,    32'h0000_0301);
`ifdef TIMER_PRESCALER_EN
        rd(A_CTRL, 32'h0000_0301, "pre_ctrl");
        step(3);
        rd(A_COUNT, 32'd0, "pre_count_t3");
        step(1);
        rd(A_COUNT, 32'd1, "pre_count_t4");
        step(4);
        rd(A_COUNT, 32'd2, "pre_count_t8");
        step(3);
        rd(A_STATUS, 32'd0, "pre_status_t11");
        step(1);
        rd(A_STATUS, 32'd1, "pre_status_t12");
        rd(A_CTRL,   32'h0000_0300, "pre_ctrl_stopped");
`else
        rd(A_CTRL, 32'h0000_0001, "nopre_ctrl");
        step(2);
        rd(A_COUNT,  32'd2, "nopre_count_t2");
        rd(A_STATUS, 32'd0, "nopre_status_t2");
        step(1);
        rd(A_STATUS, 32'd1, "nopre_status_t3");
        rd(A_CTRL,   32'h0000_0000, "nopre_ctrl_stopped");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
